// File: rtl/mpq_pop_scheduler_if.sv
// -----------------------------------------------------------------------------
// mpq_pop_scheduler_if
// Bundle of the signals between the pop scheduler, the multi-FIFO engine and
// the downstream consumer.
//
// Signals:
//   push_seen_i     engine push strobe (mirrors the engine's push input)
//   push_fifo_id_i  engine push FIFO id
//   fifo_en_i       per-FIFO drain enable mask
//   pop_o           pop strobe to the engine
//   pop_fifo_id_o   FIFO to pop
//   data_i          engine read data, valid the cycle after pop_o
//   out_valid_o     output element valid
//   out_ready_i     downstream ready
//   out_data_o      output element
//   out_fifo_id_o   source FIFO of out_data_o
//   occup_o         per-FIFO occupancy, registered
//
// Modports:
//   master  the scheduler side (drives the *_o members)
//   slave   the engine / consumer side (drives the *_i members)
// -----------------------------------------------------------------------------
interface mpq_pop_scheduler_if #(
  parameter int  NUM_FIFO  = 16,
  parameter int  MAX_OCCUP = 68,
  parameter type elem_t    = logic
);
  localparam int FW = $clog2(NUM_FIFO);
  localparam int OW = $clog2(MAX_OCCUP + 1);

  typedef logic [FW-1:0] fifo_id_t;
  typedef logic [OW-1:0] occup_t;

  logic                      push_seen_i;
  fifo_id_t                  push_fifo_id_i;
  logic [NUM_FIFO-1:0]       fifo_en_i;
  logic                      pop_o;
  fifo_id_t                  pop_fifo_id_o;
  elem_t                     data_i;
  logic                      out_valid_o;
  logic                      out_ready_i;
  elem_t                     out_data_o;
  fifo_id_t                  out_fifo_id_o;
  occup_t [NUM_FIFO-1:0]     occup_o;

  modport master (
    input  push_seen_i, push_fifo_id_i, fifo_en_i, data_i, out_ready_i,
    output pop_o, pop_fifo_id_o, out_valid_o, out_data_o, out_fifo_id_o, occup_o
  );

  modport slave (
    output push_seen_i, push_fifo_id_i, fifo_en_i, data_i, out_ready_i,
    input  pop_o, pop_fifo_id_o, out_valid_o, out_data_o, out_fifo_id_o, occup_o
  );
endinterface

// File: rtl/mpq_pop_scheduler.sv
// -----------------------------------------------------------------------------
// mpq_pop_scheduler
// Drain-side controller for the multi-FIFO cell engine. Mirrors engine pushes
// into per-FIFO occupancy counters, picks a non-empty enabled FIFO, issues one
// pop per cycle, captures the engine's 1-cycle-latency read data and presents
// it on a valid/ready stream through a 2-entry output buffer. Pops are
// throttled by credits so the buffer can never overflow.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (engine must be reset alongside)
//   bus     mpq_pop_scheduler_if.master (push mirror, enable mask, pop
//           request, read data, output stream, occupancy)
//
// Build option:
//   MPQ_POP_STRICT_PRIO_EN  when defined, the grant always goes to the
//                           lowest-index eligible FIFO (no round-robin state).
//                           When undefined, round-robin starting after the
//                           last granted FIFO.
//
// Pop-to-output latency is 2 cycles: grant at t, data_i captured at t+1,
// out_valid_o at t+2 at the earliest.
// -----------------------------------------------------------------------------
module mpq_pop_scheduler #(
  parameter int  NUM_FIFO  = 16,
  parameter int  MAX_OCCUP = 68,
  parameter type elem_t    = logic
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mpq_pop_scheduler_if.master bus
);

  localparam int FW = $clog2(NUM_FIFO);
  localparam int OW = $clog2(MAX_OCCUP + 1);

  typedef logic [FW-1:0] fifo_id_t;
  typedef logic [OW-1:0] occup_t;

  // Occupancy mirror
  occup_t [NUM_FIFO-1:0] occup_r;
  occup_t [NUM_FIFO-1:0] occup_s;
  logic                  sat_push_s;

  // Grant
  logic [NUM_FIFO-1:0]   elig_s;
  logic                  pop_allow_s;
  logic                  grant_s;
  fifo_id_t              grant_id_s;
  logic [1:0]            credit_use_s;

`ifndef MPQ_POP_STRICT_PRIO_EN
  fifo_id_t              rr_ptr_r;
`endif

  // In-flight pop
  logic                  inflight_r;
  fifo_id_t              inflight_id_r;

  // Output buffer: head entry is always what the stream presents
  logic [1:0]            buf_cnt_r;
  logic [1:0]            buf_cnt_s;
  elem_t                 head_data_r;
  elem_t                 head_data_s;
  elem_t                 tail_data_r;
  elem_t                 tail_data_s;
  fifo_id_t              head_id_r;
  fifo_id_t              head_id_s;
  fifo_id_t              tail_id_r;
  fifo_id_t              tail_id_s;
  logic                  out_valid_s;
  logic                  deq_s;

  assign out_valid_s = (buf_cnt_r != 2'd0);
  assign deq_s       = out_valid_s && bus.out_ready_i;

  // Credits count buffered entries net of this cycle's transfer plus the
  // pop whose data is still on its way; discounting the transfer is what
  // lets a steadily-drained stream sustain one pop per cycle.
  assign credit_use_s = buf_cnt_r - {1'b0, deq_s} + {1'b0, inflight_r};
  assign pop_allow_s  = (credit_use_s < 2'd2);

  // Eligibility from registered counts only, so a same-cycle push never
  // makes an engine-empty FIFO poppable.
  always_comb begin
    elig_s = {NUM_FIFO{1'b0}};
    for (int k = 0; k < NUM_FIFO; k++) begin
      elig_s[k] = (occup_r[k] != {OW{1'b0}}) && bus.fifo_en_i[k];
    end
  end

  // Arbiter: search the eligible set in priority order and pick the first hit
  always_comb begin
    int       pos;
    fifo_id_t idx;
    grant_s    = 1'b0;
    grant_id_s = {FW{1'b0}};
    pos        = 0;
    idx        = {FW{1'b0}};
    for (int k = 0; k < NUM_FIFO; k++) begin
`ifdef MPQ_POP_STRICT_PRIO_EN
      pos = k;
`else
      // first candidate is the one strictly after the last grant
      pos = int'(rr_ptr_r) + 1 + k;
      if (pos >= NUM_FIFO) begin
        pos = pos - NUM_FIFO;
      end else begin
        pos = pos;
      end
`endif
      idx = fifo_id_t'(pos);
      if (pop_allow_s && !grant_s && elig_s[idx]) begin
        grant_s    = 1'b1;
        grant_id_s = idx;
      end else begin
        grant_s    = grant_s;
        grant_id_s = grant_id_s;
      end
    end
  end

  // Next occupancy: +1 on matching push, -1 on matching grant, saturating
  always_comb begin
    logic inc_v;
    logic dec_v;
    occup_s    = occup_r;
    sat_push_s = 1'b0;
    inc_v      = 1'b0;
    dec_v      = 1'b0;
    for (int k = 0; k < NUM_FIFO; k++) begin
      inc_v = bus.push_seen_i && (bus.push_fifo_id_i == fifo_id_t'(k));
      dec_v = grant_s && (grant_id_s == fifo_id_t'(k));
      if (inc_v && !dec_v) begin
        if (occup_r[k] == occup_t'(MAX_OCCUP)) begin
          sat_push_s = 1'b1;
        end else begin
          occup_s[k] = occup_r[k] + occup_t'(1'b1);
        end
      end else if (dec_v && !inc_v) begin
        occup_s[k] = occup_r[k] - occup_t'(1'b1);
      end else begin
        occup_s[k] = occup_r[k];
      end
    end
  end

  // Output buffer next state: dequeue shifts tail to head, write lands at
  // the first free slot after the dequeue
  always_comb begin
    buf_cnt_s   = buf_cnt_r;
    head_data_s = head_data_r;
    head_id_s   = head_id_r;
    tail_data_s = tail_data_r;
    tail_id_s   = tail_id_r;
    case ({deq_s, inflight_r})
      2'b10: begin
        head_data_s = tail_data_r;
        head_id_s   = tail_id_r;
        buf_cnt_s   = buf_cnt_r - 2'd1;
      end
      2'b01: begin
        if (buf_cnt_r == 2'd0) begin
          head_data_s = bus.data_i;
          head_id_s   = inflight_id_r;
        end else begin
          tail_data_s = bus.data_i;
          tail_id_s   = inflight_id_r;
        end
        buf_cnt_s = buf_cnt_r + 2'd1;
      end
      2'b11: begin
        if (buf_cnt_r == 2'd1) begin
          head_data_s = bus.data_i;
          head_id_s   = inflight_id_r;
        end else begin
          head_data_s = tail_data_r;
          head_id_s   = tail_id_r;
          tail_data_s = bus.data_i;
          tail_id_s   = inflight_id_r;
        end
      end
      default: begin
        buf_cnt_s = buf_cnt_r;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occup_r       <= {NUM_FIFO{{OW{1'b0}}}};
      inflight_r    <= 1'b0;
      inflight_id_r <= {FW{1'b0}};
      buf_cnt_r     <= 2'd0;
      head_data_r   <= elem_t'(1'b0);
      tail_data_r   <= elem_t'(1'b0);
      head_id_r     <= {FW{1'b0}};
      tail_id_r     <= {FW{1'b0}};
    end else begin
      occup_r     <= occup_s;
      inflight_r  <= grant_s;
      if (grant_s) begin
        inflight_id_r <= grant_id_s;
      end
      buf_cnt_r   <= buf_cnt_s;
      head_data_r <= head_data_s;
      tail_data_r <= tail_data_s;
      head_id_r   <= head_id_s;
      tail_id_r   <= tail_id_s;
    end
  end

`ifndef MPQ_POP_STRICT_PRIO_EN
  // Round-robin pointer follows the last grant; reset value makes FIFO 0 first
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= fifo_id_t'(NUM_FIFO - 1);
    end else if (grant_s) begin
      rr_ptr_r <= grant_id_s;
    end
  end
`endif

  assign bus.pop_o         = grant_s;
  assign bus.pop_fifo_id_o = grant_id_s;
  assign bus.out_valid_o   = out_valid_s;
  assign bus.out_data_o    = head_data_r;
  assign bus.out_fifo_id_o = head_id_r;
  assign bus.occup_o       = occup_r;

`ifndef SYNTHESIS
  mpq_pop_scheduler_chk #(
    .FW     (FW),
    .elem_t (elem_t)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .sat_push_i    (sat_push_s),
    .out_valid_i   (out_valid_s),
    .out_ready_i   (bus.out_ready_i),
    .out_data_i    (head_data_r),
    .out_fifo_id_i (head_id_r)
  );
`endif

endmodule

`ifndef SYNTHESIS
// -----------------------------------------------------------------------------
// mpq_pop_scheduler_chk
// Protocol checks for the pop scheduler: occupancy overflow from upstream and
// output stream stability under backpressure.
// -----------------------------------------------------------------------------
module mpq_pop_scheduler_chk #(
  parameter int  FW     = 4,
  parameter type elem_t = logic
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic          sat_push_i,
  input logic          out_valid_i,
  input logic          out_ready_i,
  input elem_t         out_data_i,
  input logic [FW-1:0] out_fifo_id_i
);

  // a push into a full FIFO means upstream broke its contract
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !sat_push_i);

  // a stalled element must stay put until it is taken
  a_stream_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_i && !out_ready_i) |=>
      (out_valid_i && $stable(out_data_i) && $stable(out_fifo_id_i)));

endmodule
`endif

// File: tb/tb_mpq_pop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mpq_pop_scheduler
// Self-checking bench for mpq_pop_scheduler. The bench plays the engine
// (per-FIFO element queues) and the consumer; expected stream contents,
// pop decisions and occupancies come from a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_mpq_pop_scheduler;

  localparam int NF = 16;
  localparam int MO = 68;
  localparam int FW = $clog2(NF);
  localparam int OW = $clog2(MO + 1);

  typedef logic [7:0] elem_t;
  typedef struct {
    logic [7:0] d;
    int         id;
  } ent_t;

  logic clk;
  logic rst_ni;

  int compared;
  int mismatched;

  // reference model state
  logic [7:0] fq [NF][$];   // engine contents per FIFO
  ent_t       outq[$];      // elements buffered at the output
  bit         m_inf;        // a pop is in flight
  int         m_inf_id;
  logic [7:0] m_inf_d;
  int         m_rr;         // last granted FIFO

  mpq_pop_scheduler_if #(.NUM_FIFO(NF), .MAX_OCCUP(MO), .elem_t(elem_t)) bus ();

  mpq_pop_scheduler #(
    .NUM_FIFO  (NF),
    .MAX_OCCUP (MO),
    .elem_t    (elem_t)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NF; k++) fq[k].delete();
    outq.delete();
    m_inf    = 1'b0;
    m_inf_id = 0;
    m_inf_d  = 8'h00;
    m_rr     = NF - 1;
  endtask

  task automatic chk_reset_state();
    chk("rst_pop",     128'(bus.pop_o), 128'(0));
    chk("rst_pop_id",  128'(bus.pop_fifo_id_o), 128'(0));
    chk("rst_valid",   128'(bus.out_valid_o), 128'(0));
    chk("rst_data",    128'(bus.out_data_o), 128'(0));
    chk("rst_fid",     128'(bus.out_fifo_id_o), 128'(0));
    chk("rst_occup",   128'(bus.occup_o), 128'(0));
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model to what the coming rising edge should produce.
  task automatic cycle(input bit push, input int pid, input logic [NF-1:0] en,
                       input bit rdy, input int dat);
    bit         deq;
    bit         allow;
    bit         gnt;
    int         gid;
    logic [7:0] pd;
    logic [127:0] exp_occ;
    @(negedge clk);
    pd = (dat < 0) ? 8'($urandom) : 8'(dat);
    bus.push_seen_i    = push;
    bus.push_fifo_id_i = FW'(pid);
    bus.fifo_en_i      = en;
    bus.out_ready_i    = rdy;
    bus.data_i         = m_inf ? m_inf_d : 8'($urandom);
    #1;
    deq   = (outq.size() > 0) && rdy;
    allow = (outq.size() - int'(deq) + int'(m_inf)) < 2;
    gnt   = 1'b0;
    gid   = 0;
    if (allow) begin
`ifdef MPQ_POP_STRICT_PRIO_EN
      for (int k = 0; k < NF; k++) begin
        if (!gnt && fq[k].size() > 0 && en[k]) begin
          gnt = 1'b1;
          gid = k;
        end
      end
`else
      for (int k = 1; k <= NF; k++) begin
        int c;
        c = (m_rr + k) % NF;
        if (!gnt && fq[c].size() > 0 && en[c]) begin
          gnt = 1'b1;
          gid = c;
        end
      end
`endif
    end
    exp_occ = '0;
    for (int k = 0; k < NF; k++) exp_occ[k*OW +: OW] = OW'(fq[k].size());
    chk("pop",    128'(bus.pop_o), 128'(gnt));
    chk("pop_id", 128'(bus.pop_fifo_id_o), 128'(gid));
    chk("valid",  128'(bus.out_valid_o), 128'(outq.size() > 0));
    if (outq.size() > 0) begin
      chk("out_data", 128'(bus.out_data_o), 128'(outq[0].d));
      chk("out_fid",  128'(bus.out_fifo_id_o), 128'(outq[0].id));
    end
    chk("occup", 128'(bus.occup_o), exp_occ);
    // advance model
    if (deq) void'(outq.pop_front());
    if (m_inf) outq.push_back('{m_inf_d, m_inf_id});
    if (gnt) begin
      m_inf_d  = fq[gid].pop_front();
      m_inf_id = gid;
      m_rr     = gid;
    end
    m_inf = gnt;
    if (push) fq[pid].push_back(pd);
  endtask

  task automatic idle(input int n, input logic [NF-1:0] en, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, en, rdy, -1);
  endtask

  initial begin
    int pid;
    bit push;
    logic [NF-1:0] en;
    compared   = 0;
    mismatched = 0;
    rst_ni = 1'b0;
    bus.push_seen_i    = 1'b0;
    bus.push_fifo_id_i = '0;
    bus.fifo_en_i      = '0;
    bus.data_i         = '0;
    bus.out_ready_i    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst_ni = 1'b1;

    // single element: push FIFO 3 with 0xA5
    cycle(1'b1, 3, '1, 1'b1, 8'hA5);
    idle(5, '1, 1'b1);

    // round-robin across FIFOs 0, 2, 5 (preloaded while disabled)
    for (int r = 0; r < 2; r++) begin
      cycle(1'b1, 0, '0, 1'b1, -1);
      cycle(1'b1, 2, '0, 1'b1, -1);
      cycle(1'b1, 5, '0, 1'b1, -1);
    end
    idle(10, '1, 1'b1);

    // backpressure: 4 in FIFO 1, consumer stalled then released
    for (int r = 0; r < 4; r++) cycle(1'b1, 1, '0, 1'b0, -1);
    idle(6, '1, 1'b0);
    idle(8, '1, 1'b1);

    // mask: FIFO 0 held back while only FIFO 1 is enabled
    for (int r = 0; r < 2; r++) begin
      cycle(1'b1, 0, '0, 1'b1, -1);
      cycle(1'b1, 1, '0, 1'b1, -1);
    end
    idle(6, 16'h0002, 1'b1);
    idle(6, '1, 1'b1);

    // same-cycle push and pop on FIFO 4
    cycle(1'b1, 4, '0, 1'b1, -1);
    cycle(1'b1, 4, '1, 1'b1, -1);
    idle(5, '1, 1'b1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      pid  = $urandom_range(0, NF - 1);
      push = ($urandom_range(0, 2) != 0) && (fq[pid].size() < MO - 2);
      en   = ($urandom_range(0, 3) == 0) ? NF'($urandom) : '1;
      cycle(push, pid, en, $urandom_range(0, 3) != 0, -1);
    end
    idle(20, '1, 1'b1);

    // reset mid-stream with a full output buffer and data still queued
    for (int r = 0; r < 4; r++) cycle(1'b1, 6, '0, 1'b0, -1);
    idle(4, '1, 1'b0);
    @(negedge clk);
    rst_ni = 1'b0;
    #1;
    chk_reset_state();
    model_reset();
    idle(2, '0, 1'b1);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk_reset_state();
    cycle(1'b1, 9, '1, 1'b1, -1);
    idle(5, '1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
